// File: rtl/vga_pkg.sv
// Shared VGA ball definitions: screen geometry defaults, the motion FSM state type
// and the RGB444 ball palette.
package vga_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int BALL_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_H = 2'd1,
    STEP_V = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Entry 0 is the reset colour (white); the others are cycled through on bounces.
  localparam logic [11:0] PALETTE [8] = '{
    12'hFFF, 12'hF00, 12'h0F0, 12'h00F,
    12'hFF0, 12'h0FF, 12'hF0F, 12'hF80
  };

endpackage

// File: rtl/ball_axis_step.sv
// One-axis position step with edge reflection. This block is purely combinational.
// Arithmetic is done one bit wider than the position, so pos + STEP cannot wrap.
module ball_axis_step #(
  parameter int W    = 10,
  parameter int MAX  = 632,
  parameter int STEP = 1
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  output logic [W-1:0] next_pos,
  output logic         next_dir,
  output logic         hit
);

  logic [W:0] pos_ext;
  logic [W:0] step_ext;
  logic [W:0] max_ext;
  logic [W:0] sum;
  logic [W:0] diff;

  assign pos_ext  = {1'b0, pos};
  assign step_ext = (W+1)'(STEP);
  assign max_ext  = (W+1)'(MAX);
  assign sum      = pos_ext + step_ext;
  assign diff     = pos_ext - step_ext;

  always_comb begin
    // NOTE: every output gets a default before the branches, so no path can infer a latch.
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (dir) begin
      if (sum > max_ext) begin
        next_pos = W'(MAX);
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = sum[W-1:0];
      end
    end else begin
      if (pos_ext < step_ext) begin
        next_pos = '0;
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = diff[W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-rate ball motion scheduler: IDLE -> STEP_H -> STEP_V -> COMMIT. Both coordinates
// land in one cycle. Define BALL_COLOUR_EN to make the ball cycle through the palette on each bounce.
module ball_motion_ctrl #(
  parameter int H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int BALL_SIZE = vga_pkg::BALL_SIZE,
  parameter int STEP_H    = 1,
  parameter int STEP_V    = 1,
  parameter int H_W       = 10,
  parameter int V_W       = 10,
  parameter int INIT_H    = 320,
  parameter int INIT_V    = 240
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           pause,
  output logic [H_W-1:0] ball_h,
  output logic [V_W-1:0] ball_v,
  output logic           dir_h,
  output logic           dir_v,
  output logic           bounce,
  output logic           update_done,
  output logic           overrun,
  output logic [11:0]    ball_colour
);

  localparam int MAX_H = H_ACTIVE - BALL_SIZE;
  localparam int MAX_V = V_ACTIVE - BALL_SIZE;

  vga_pkg::state_t state_q;

  logic [H_W-1:0] ball_h_q, shadow_h_q, h_pos_d;
  logic [V_W-1:0] ball_v_q, shadow_v_q, v_pos_d;
  logic           dir_h_q, dir_v_q, shadow_dir_h_q, shadow_dir_v_q;
  logic           hit_h_q, hit_v_q, h_dir_d, v_dir_d, h_hit_d, v_hit_d;
  logic           bounce_q, update_done_q, overrun_q;

  ball_axis_step #(.W(H_W), .MAX(MAX_H), .STEP(STEP_H)) u_step_h (
    .pos      (ball_h_q),
    .dir      (dir_h_q),
    .next_pos (h_pos_d),
    .next_dir (h_dir_d),
    .hit      (h_hit_d)
  );

  ball_axis_step #(.W(V_W), .MAX(MAX_V), .STEP(STEP_V)) u_step_v (
    .pos      (ball_v_q),
    .dir      (dir_v_q),
    .next_pos (v_pos_d),
    .next_dir (v_dir_d),
    .hit      (v_hit_d)
  );

`ifdef BALL_COLOUR_EN
  logic [2:0]  colour_idx_q;
  logic [2:0]  colour_idx_d;
  logic [11:0] colour_q;

  assign colour_idx_d = colour_idx_q + 3'd1;
  assign ball_colour  = colour_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      colour_idx_q <= 3'd0;
      colour_q     <= vga_pkg::PALETTE[0];
    end else if (state_q == vga_pkg::COMMIT && (hit_h_q || hit_v_q)) begin
      colour_idx_q <= colour_idx_d;
      colour_q     <= vga_pkg::PALETTE[colour_idx_d];
    end
  end
`else
  assign ball_colour = 12'hFFF;
`endif

  always_ff @(posedge clk) begin
    // NOTE: all state is updated with non-blocking assignments, so every branch reads pre-edge values.
    if (rst) begin
      state_q        <= vga_pkg::IDLE;
      ball_h_q       <= H_W'(INIT_H);
      ball_v_q       <= V_W'(INIT_V);
      dir_h_q        <= 1'b1;
      dir_v_q        <= 1'b1;
      // NOTE: the shadow registers are reset too. A reset mid-update then leaves no stale half-step behind.
      shadow_h_q     <= '0;
      shadow_v_q     <= '0;
      shadow_dir_h_q <= 1'b1;
      shadow_dir_v_q <= 1'b1;
      hit_h_q        <= 1'b0;
      hit_v_q        <= 1'b0;
      bounce_q       <= 1'b0;
      update_done_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      bounce_q      <= 1'b0;
      update_done_q <= 1'b0;
      overrun_q     <= frame_tick && (state_q != vga_pkg::IDLE);
      case (state_q)
        vga_pkg::IDLE: begin
          if (frame_tick && !pause) state_q <= vga_pkg::STEP_H;
        end
        vga_pkg::STEP_H: begin
          shadow_h_q     <= h_pos_d;
          shadow_dir_h_q <= h_dir_d;
          hit_h_q        <= h_hit_d;
          state_q        <= vga_pkg::STEP_V;
        end
        vga_pkg::STEP_V: begin
          shadow_v_q     <= v_pos_d;
          shadow_dir_v_q <= v_dir_d;
          hit_v_q        <= v_hit_d;
          state_q        <= vga_pkg::COMMIT;
        end
        vga_pkg::COMMIT: begin
          ball_h_q      <= shadow_h_q;
          ball_v_q      <= shadow_v_q;
          dir_h_q       <= shadow_dir_h_q;
          dir_v_q       <= shadow_dir_v_q;
          update_done_q <= 1'b1;
          bounce_q      <= hit_h_q || hit_v_q;
          state_q       <= vga_pkg::IDLE;
        end
        default: state_q <= vga_pkg::IDLE;
      endcase
    end
  end

  assign ball_h      = ball_h_q;
  assign ball_v      = ball_v_q;
  assign dir_h       = dir_h_q;
  assign dir_v       = dir_v_q;
  assign bounce      = bounce_q;
  assign update_done = update_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: three instances (default screen, a tiny screen that hits
// corners, a near-edge start) checked every cycle against a frame-level reference model.
module tb_ball_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic pause = 1'b0;

  logic [9:0]  bh [3];
  logic [9:0]  bv [3];
  logic        dh [3];
  logic        dv [3];
  logic        bnc [3];
  logic        done [3];
  logic        ovr [3];
  logic [11:0] col [3];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  ball_motion_ctrl u_dut_main (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause),
    .ball_h(bh[0]), .ball_v(bv[0]), .dir_h(dh[0]), .dir_v(dv[0]),
    .bounce(bnc[0]), .update_done(done[0]), .overrun(ovr[0]), .ball_colour(col[0])
  );

  ball_motion_ctrl #(.H_ACTIVE(16), .V_ACTIVE(16), .BALL_SIZE(8), .INIT_H(0), .INIT_V(0)) u_dut_small (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause),
    .ball_h(bh[1]), .ball_v(bv[1]), .dir_h(dh[1]), .dir_v(dv[1]),
    .bounce(bnc[1]), .update_done(done[1]), .overrun(ovr[1]), .ball_colour(col[1])
  );

  ball_motion_ctrl #(.INIT_H(631)) u_dut_edge (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .pause(pause),
    .ball_h(bh[2]), .ball_v(bv[2]), .dir_h(dh[2]), .dir_v(dv[2]),
    .bounce(bnc[2]), .update_done(done[2]), .overrun(ovr[2]), .ball_colour(col[2])
  );

  typedef struct {
    int h;
    int v;
    bit dh;
    bit dv;
    int cidx;
    int busy;   // cycles since the accepted tick; 0 when free to accept
    bit done;
    bit bnc;
    bit ovr;
  } model_t;

  localparam int MAXH [3]  = '{632, 8, 632};
  localparam int MAXV [3]  = '{472, 8, 472};
  localparam int INITH [3] = '{320, 0, 631};
  localparam int INITV [3] = '{240, 0, 240};

  model_t m [3];

  // Reflecting step of one coordinate on the frame level.
  function automatic void move(input int pos, input bit dir, input int max, input int step,
                               output int npos, output bit ndir);
    ndir = dir;
    if (dir && pos + step > max) begin
      npos = max;
      ndir = 1'b0;
    end else if (!dir && pos < step) begin
      npos = 0;
      ndir = 1'b1;
    end else begin
      npos = dir ? pos + step : pos - step;
    end
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m[i] = '{h: INITH[i], v: INITV[i], dh: 1'b1, dv: 1'b1, cidx: 0,
                 busy: 0, done: 1'b0, bnc: 1'b0, ovr: 1'b0};
      end else begin
        int nh, nv;
        bit ndh, ndv;
        m[i].ovr  = frame_tick && (m[i].busy != 0);
        m[i].done = 1'b0;
        m[i].bnc  = 1'b0;
        if (m[i].busy == 0) begin
          if (frame_tick && !pause) m[i].busy = 1;
        end else if (m[i].busy == 3) begin
          move(m[i].h, m[i].dh, MAXH[i], 1, nh, ndh);
          move(m[i].v, m[i].dv, MAXV[i], 1, nv, ndv);
          m[i].bnc  = (ndh != m[i].dh) || (ndv != m[i].dv);
          m[i].done = 1'b1;
          m[i].h    = nh;
          m[i].v    = nv;
          m[i].dh   = ndh;
          m[i].dv   = ndv;
          if (m[i].bnc) m[i].cidx = (m[i].cidx + 1) % 8;
          m[i].busy = 0;
        end else begin
          m[i].busy++;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_colour(input int idx);
`ifdef BALL_COLOUR_EN
    return vga_pkg::PALETTE[idx];
`else
    return (idx >= 0) ? 12'hFFF : 12'hFFF;
`endif
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ball_h[%0d]", i), 16'(bh[i]), 16'(m[i].h));
      check($sformatf("ball_v[%0d]", i), 16'(bv[i]), 16'(m[i].v));
      check($sformatf("dir_h[%0d]", i), 16'(dh[i]), 16'(m[i].dh));
      check($sformatf("dir_v[%0d]", i), 16'(dv[i]), 16'(m[i].dv));
      check($sformatf("bounce[%0d]", i), 16'(bnc[i]), 16'(m[i].bnc));
      check($sformatf("update_done[%0d]", i), 16'(done[i]), 16'(m[i].done));
      check($sformatf("overrun[%0d]", i), 16'(ovr[i]), 16'(m[i].ovr));
      check($sformatf("colour[%0d]", i), 16'(col[i]), 16'(exp_colour(m[i].cidx)));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // One-cycle tick, then run on to the cycle in which the update lands.
  task automatic pulse_tick();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    repeat (3) cycle();
  endtask

  initial begin
    // Reset, then idle: reset values hold and no pulses fire.
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (5) cycle();
    check("reset_ball_h", 16'(bh[0]), 16'd320);
    check("reset_ball_v", 16'(bv[0]), 16'd240);
    check("reset_colour", 16'(col[0]), 16'hFFF);

    // A tick from reset commits three edges later, and update_done lasts one cycle.
    pulse_tick();
    check("t2_ball_h", 16'(bh[0]), 16'd321);
    check("t2_ball_v", 16'(bv[0]), 16'd241);
    check("t2_done", 16'(done[0]), 16'd1);
    check("edge_t1_h", 16'(bh[2]), 16'd632);
    check("edge_t1_bounce", 16'(bnc[2]), 16'd0);
    cycle();
    check("t2_done_drop", 16'(done[0]), 16'd0);

    // Right edge: clamp at MAX, then reverse, then move left.
    pulse_tick();
    check("edge_t2_h", 16'(bh[2]), 16'd632);
    check("edge_t2_dir", 16'(dh[2]), 16'd0);
    check("edge_t2_bounce", 16'(bnc[2]), 16'd1);
    pulse_tick();
    check("edge_t3_h", 16'(bh[2]), 16'd631);

    // Small screen: the ninth update reaches the corner, and both axes flip together.
    repeat (5) pulse_tick();
    check("corner_pre_h", 16'(bh[1]), 16'd8);
    pulse_tick();
    check("corner_dir_h", 16'(dh[1]), 16'd0);
    check("corner_dir_v", 16'(dv[1]), 16'd0);
    check("corner_bounce", 16'(bnc[1]), 16'd1);
`ifdef BALL_COLOUR_EN
    check("corner_colour", 16'(col[1]), 16'(vga_pkg::PALETTE[1]));
`endif
    cycle();
    check("corner_bounce_drop", 16'(bnc[1]), 16'd0);

    // While paused, ticks are ignored.
    pause = 1'b1;
    repeat (3) pulse_tick();
    check("pause_ball_h", 16'(bh[0]), 16'd329);
    check("pause_done", 16'(done[0]), 16'd0);
    pause = 1'b0;

    // A back-to-back tick gives overrun and still only one update.
    frame_tick = 1'b1;
    cycle();
    cycle();
    check("overrun_pulse", 16'(ovr[0]), 16'd1);
    frame_tick = 1'b0;
    cycle();
    check("overrun_drop", 16'(ovr[0]), 16'd0);
    cycle();
    check("overrun_single_h", 16'(bh[0]), 16'd330);
    check("overrun_single_done", 16'(done[0]), 16'd1);

    // A reset during STEP_V aborts the update, and the next tick behaves like the first.
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    check("abort_ball_h", 16'(bh[0]), 16'd320);
    check("abort_done", 16'(done[0]), 16'd0);
    rst = 1'b0;
    cycle();
    pulse_tick();
    check("after_abort_h", 16'(bh[0]), 16'd321);
    check("after_abort_done", 16'(done[0]), 16'd1);

    // Random tick, pause and reset traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      pause      = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
